// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
//
// Contents: FSM state encodings (as constants and as an enum view),
// the iteration counter width helper and the product width helper.
package seq_mult_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Enum view of the same encodings, handy for typed debug signals.
    typedef enum logic [0:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN
    } state_e;

    // Counter must hold WIDTH itself, hence WIDTH+1 codes.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic int prod_width(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/seq_mult_ctrl.sv
// Sequencer for seq_mult: IDLE/RUN FSM, iteration counter, busy and done.
// Latency: start accepted at edge k, done high in the cycle after edge k+WIDTH.
// Backpressure: start is only honoured while busy=0; it is dropped otherwise.
//
// Ports:
//   clk, rst_n  rising-edge clock, asynchronous active-low reset
//   start       operation request
//   busy        high for the WIDTH cycles of an operation
//   done        registered one-cycle completion pulse
//   accept      combinational: start taken at this edge (datapath load)
//   last        combinational: this edge is the final iteration
module seq_mult_ctrl
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic busy,
    output logic done,
    output logic accept,
    output logic last
);

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;

    assign busy   = (state == ST_RUN);
    assign accept = start && !busy;
    assign last   = busy && (cnt == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_RUN;
                        cnt   <= CNT_W'(WIDTH);
                    end
                end
                ST_RUN: begin
                    cnt <= cnt - CNT_W'(1);
                    // Leaving on the 1->0 step; done lines up with the
                    // product register update in the datapath.
                    if (cnt == CNT_W'(1)) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/seq_mult.sv
// Sequential shift-and-add multiplier, one operation in flight, result held.
// Latency: fixed WIDTH+1 cycles from accepted start to done (throughput 1/(WIDTH+1)).
// Backpressure: start while busy is ignored; no queueing, operands not re-sampled.
//
// Ports:
//   clk, rst_n  rising-edge clock, asynchronous active-low reset
//   start       request, sampled only while busy=0
//   a, b        WIDTH-bit operands, captured on accepted start
//   busy        operation running
//   done        one-cycle pulse when product is updated
//   product     2*WIDTH-bit last completed result
// Build option: define SEQ_MULT_SIGNED_EN for two's complement operands.
module seq_mult
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam int PW    = prod_width(WIDTH);

    logic             accept;
    logic             last;
    logic [PW-1:0]    a_reg;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    acc_next;
    logic [PW-1:0]    result;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;

    seq_mult_ctrl #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_ctrl (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .accept (accept),
        .last   (last)
    );

    // Add is bounded by a*b < 2^PW, so truncation never loses bits.
    assign acc_next = b_reg[0] ? (acc + a_reg) : acc;

`ifdef SEQ_MULT_SIGNED_EN
    logic neg;

    // Magnitudes: -2^(WIDTH-1) negates to itself, which read unsigned
    // is exactly 2^(WIDTH-1), so no extra bit is needed.
    assign a_in   = a[WIDTH-1] ? -a : a;
    assign b_in   = b[WIDTH-1] ? -b : b;
    assign result = neg ? -acc_next : acc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg <= 1'b0;
        end else if (accept) begin
            neg <= a[WIDTH-1] ^ b[WIDTH-1];
        end
    end
`else
    assign a_in   = a;
    assign b_in   = b;
    assign result = acc_next;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg   <= '0;
            b_reg   <= '0;
            acc     <= '0;
            product <= '0;
        end else if (accept) begin
            a_reg <= {{WIDTH{1'b0}}, a_in};
            b_reg <= b_in;
            acc   <= '0;
        end else if (busy) begin
            acc   <= acc_next;
            a_reg <= a_reg << 1;
            b_reg <= b_reg >> 1;
            // Final iteration's add is folded into the published result.
            if (last) begin
                product <= result;
            end
        end
    end

endmodule
